// File: rtl/scan_mux.sv
// scan_mux: registered N-channel selector with manual select and an automatic
// round-robin scan. In scan mode each channel is held for DWELL enabled clocks.
// out and channel are updated on the same edge, so they always agree. strobe
// pulses for one clock whenever channel changes. valid goes high on the first
// enabled edge after clear and stays high until clear is asserted again.
module scan_mux #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2,
   parameter int DWELL    = 4
) (
   input  logic                      clock,
   input  logic                      clear,
   input  logic                      enable,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          select,
   input  logic                      hold,
   input  logic [CHANNELS*WIDTH-1:0] in_bus,
   output logic [WIDTH-1:0]          out,
   output logic [SEL_W-1:0]          channel,
   output logic                      strobe,
   output logic                      valid
);

   localparam int                CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int                NSLOT    = 2 ** SEL_W;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [SEL_W:0]    CH_LIM   = (SEL_W + 1)'(CHANNELS);
   localparam logic [SEL_W-1:0]  CH_LAST  = SEL_W'(CHANNELS - 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [SEL_W-1:0] ch_next;
   logic [WIDTH-1:0] chan_data [NSLOT];

   // Unpack the input bus into an array sized to the full select range.
   // Slots past CHANNELS read as zero, but ch_next never points at them.
   for (genvar k = 0; k < NSLOT; k++) begin : g_slot
      if (k < CHANNELS) begin : g_used
         assign chan_data[k] = in_bus[k*WIDTH +: WIDTH];
      end else begin : g_unused
         assign chan_data[k] = '0;
      end
   end

   // Work out the next channel and the next dwell count from the mode inputs.
   always_comb begin
      cnt_next = cnt;
      ch_next  = channel;
      if (!mode) begin
         cnt_next = '0;
         if ({1'b0, select} < CH_LIM) begin
            ch_next = select;
         end
      end else if (!hold) begin
         if (cnt == CNT_LAST) begin
            cnt_next = '0;
            ch_next  = (channel == CH_LAST) ? '0 : channel + 1'b1;
         end else begin
            cnt_next = cnt + 1'b1;
         end
      end
   end

   // Register the selected data together with its index, the change strobe
   // and the sticky valid flag. When enable is low, state holds and strobe drops.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         cnt     <= '0;
         channel <= '0;
         out     <= '0;
         strobe  <= 1'b0;
         valid   <= 1'b0;
      end else if (enable) begin
         cnt     <= cnt_next;
         channel <= ch_next;
         out     <= chan_data[ch_next];
         strobe  <= (ch_next != channel);
         valid   <= 1'b1;
      end else begin
         strobe  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_scan_mux.sv
// Testbench for scan_mux. The driver applies directed vectors and queues the
// expected outputs for each one. A monitor wakes on every clock edge and on
// every clear assertion, and compares the DUT outputs against everything queued.
// A second instance built with CHANNELS=3 exercises an out-of-range select.
module tb_scan_mux;

   logic        clk    = 1'b0;
   logic        clear  = 1'b0;
   logic        enable = 1'b0;
   logic        mode   = 1'b0;
   logic        hold   = 1'b0;
   logic [1:0]  select = 2'd0;
   logic [31:0] in_bus;
   logic [31:0] bus_next;

   logic [7:0]  out_a;
   logic [1:0]  ch_a;
   logic        st_a, va_a;
   logic [7:0]  out_b;
   logic [1:0]  ch_b;
   logic        st_b, va_b;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [11:0] v;
      bit          d3;
      string       name;
   } exp_t;

   exp_t        sb[$];
   exp_t        cur;
   logic [11:0] got;
   logic [7:0]  dat[4];

   scan_mux #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .DWELL(4)) u_dut (
      .clock(clk), .clear(clear), .enable(enable), .mode(mode),
      .select(select), .hold(hold), .in_bus(in_bus),
      .out(out_a), .channel(ch_a), .strobe(st_a), .valid(va_a)
   );

   scan_mux #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .DWELL(4)) u_dut3 (
      .clock(clk), .clear(clear), .enable(enable), .mode(mode),
      .select(select), .hold(hold), .in_bus(in_bus[23:0]),
      .out(out_b), .channel(ch_b), .strobe(st_b), .valid(va_b)
   );

   always #5 clk = ~clk;

   function automatic void push(bit d3, logic [7:0] o, logic [1:0] c,
                                logic s, logic v, string n);
      exp_t e;
      e.v    = {o, c, s, v};
      e.d3   = d3;
      e.name = n;
      sb.push_back(e);
   endfunction

   task automatic step(input logic en, input logic md, input logic [1:0] sl,
                       input logic hd);
      @(negedge clk);
      enable = en;
      mode   = md;
      select = sl;
      hold   = hd;
      in_bus = bus_next;
      @(posedge clk);
   endtask

   // Assert clear between clock edges, queue the reset values for an
   // immediate check, then release clear with enable low.
   task automatic do_clear(input string n);
      @(negedge clk);
      #1;
      clear  = 1'b0;
      enable = 1'b0;
      push(0, 8'h00, 2'd0, 1'b0, 1'b0, n);
      push(1, 8'h00, 2'd0, 1'b0, 1'b0, n);
      @(negedge clk);
      clear = 1'b1;
   endtask

   // Monitor: compare every queued expectation shortly after each DUT event.
   initial begin
      forever begin
         @(posedge clk or negedge clear);
         #2;
         while (sb.size() > 0) begin
            cur = sb.pop_front();
            got = cur.d3 ? {out_b, ch_b, st_b, va_b} : {out_a, ch_a, st_a, va_a};
            checks++;
            if (got !== cur.v) begin
               errors++;
               $display("FAIL %s: got out=%h ch=%0d strobe=%b valid=%b, required out=%h ch=%0d strobe=%b valid=%b",
                        cur.name, got[11:4], got[3:2], got[1], got[0],
                        cur.v[11:4], cur.v[3:2], cur.v[1], cur.v[0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      bus_next = 32'h44332211;
      in_bus   = bus_next;

      // Clear held low: both instances report reset values.
      step(0, 0, 2'd0, 0);
      push(0, 8'h00, 2'd0, 0, 0, "reset");
      push(1, 8'h00, 2'd0, 0, 0, "reset3");
      @(negedge clk);
      clear = 1'b1;

      // Manual select, including an out-of-range select on the 3-channel instance.
      step(1, 0, 2'd2, 0);
      push(0, 8'h33, 2'd2, 1, 1, "man_sel2");
      push(1, 8'h33, 2'd2, 1, 1, "man3_sel2");
      step(1, 0, 2'd2, 0);
      push(0, 8'h33, 2'd2, 0, 1, "man_sel2_nostrobe");
      step(1, 0, 2'd3, 0);
      push(0, 8'h44, 2'd3, 1, 1, "man_sel3");
      push(1, 8'h33, 2'd2, 0, 1, "oor_sel3");
      step(1, 0, 2'd3, 0);
      push(1, 8'h33, 2'd2, 0, 1, "oor_sel3_again");
      step(1, 0, 2'd1, 0);
      push(0, 8'h22, 2'd1, 1, 1, "man_sel1");
      push(1, 8'h22, 2'd1, 1, 1, "man3_sel1");

      // Auto scan from reset: each channel is held for 4 clocks, then wraps.
      do_clear("clear_before_scan");
      dat = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int k = 1; k <= 22; k++) begin
         step(1, 1, 2'd0, 0);
         push(0, dat[(k / 4) % 4], 2'((k / 4) % 4), (k % 4) == 0, 1, "auto_scan");
      end

      // Hold with the counter at 2 on channel 1; channel 1 data changes meanwhile.
      step(1, 1, 2'd0, 1);
      push(0, 8'h22, 2'd1, 0, 1, "hold1");
      bus_next = 32'h44335A11;
      step(1, 1, 2'd0, 1);
      push(0, 8'h5A, 2'd1, 0, 1, "hold_resample");
      for (int k = 0; k < 3; k++) begin
         step(1, 1, 2'd0, 1);
         push(0, 8'h5A, 2'd1, 0, 1, "hold_frozen");
      end
      step(1, 1, 2'd0, 0);
      push(0, 8'h5A, 2'd1, 0, 1, "hold_release1");
      step(1, 1, 2'd0, 0);
      push(0, 8'h33, 2'd2, 1, 1, "hold_release_adv");

      // Enable low for 3 clocks mid-dwell; the scan then resumes at the same count.
      step(1, 1, 2'd0, 0);
      push(0, 8'h33, 2'd2, 0, 1, "pre_disable");
      bus_next = 32'h44C35A11;
      for (int k = 0; k < 3; k++) begin
         step(0, 1, 2'd0, 0);
         push(0, 8'h33, 2'd2, 0, 1, "disabled_hold");
      end
      step(1, 1, 2'd0, 0);
      push(0, 8'hC3, 2'd2, 0, 1, "resume1");
      step(1, 1, 2'd0, 0);
      push(0, 8'hC3, 2'd2, 0, 1, "resume2");
      step(1, 1, 2'd0, 0);
      push(0, 8'h44, 2'd3, 1, 1, "resume_adv");

      // Switch to manual mid-dwell, then back to auto: counter restarts from 0.
      step(1, 1, 2'd0, 0);
      push(0, 8'h44, 2'd3, 0, 1, "auto_cnt1");
      step(1, 0, 2'd0, 0);
      push(0, 8'h11, 2'd0, 1, 1, "mode_to_manual");
      for (int k = 1; k <= 4; k++) begin
         step(1, 1, 2'd0, 0);
         push(0, (k == 4) ? 8'h5A : 8'h11, (k == 4) ? 2'd1 : 2'd0, k == 4, 1,
              "manual_to_auto");
      end

      // Scan forward to channel 3 mid-dwell, then clear asynchronously.
      dat = '{8'h11, 8'h5A, 8'hC3, 8'h44};
      for (int k = 1; k <= 9; k++) begin
         step(1, 1, 2'd0, 0);
         push(0, dat[1 + k / 4], 2'(1 + k / 4), (k % 4) == 0, 1, "scan_to_ch3");
      end
      do_clear("async_clear");

      // After release, the first channel change comes after a full dwell.
      for (int k = 1; k <= 4; k++) begin
         step(1, 1, 2'd0, 0);
         push(0, (k == 4) ? 8'h5A : 8'h11, (k == 4) ? 2'd1 : 2'd0, k == 4, 1,
              "post_clear");
      end

      repeat (3) @(posedge clk);
      #3;
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d unchecked entries, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/scan_mux.md
Name: scan_mux

Overview:
Parametrised, registered N-channel selector that generalises the two-input 8-bit mux. It adds an automatic round-robin scan mode with a programmable dwell time, a manual select mode, a hold control, a channel-change strobe and an output-valid flag. It sits between multiple data sources (e.g. display digit registers) and a single consumer that scans them.

Parameters:
WIDTH, 8, data width of each channel and of out
CHANNELS, 4, number of input channels (2..16)
SEL_W, 2, width of Select/Channel; must satisfy 2**SEL_W >= CHANNELS
DWELL, 4, clocks spent on each channel in auto mode (>=1)

Ports:
Clock  input  1  system clock, rising edge
Clear  input  1  asynchronous active-low reset
Enable  input  1  1 = block advances/updates; 0 = all state frozen
Mode  input  1  0 = manual select, 1 = auto scan
Select  input  SEL_W  channel index used in manual mode
Hold  input  1  auto mode only: freeze dwell counter and channel
in_bus  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
out  output  WIDTH  registered data of current channel
Channel  output  SEL_W  registered index of channel driving out
Strobe  output  1  one-cycle pulse when Channel changes value
Valid  output  1  out holds sampled data since reset

Behaviour:
- Clock is one clock; reset is asynchronous, active-low (Clear=0 resets immediately, independent of Clock).
- Reset values: out=0, Channel=0, Strobe=0, Valid=0, internal dwell counter=0.
- All outputs are registered; nothing combinational from inputs to outputs.
- Each rising edge with Enable=1: compute ch_next, then Channel<=ch_next and out<=in_bus slice[ch_next]. out and Channel are always mutually consistent. Latency is 1 clock from in_bus to out.
- Valid<=1 on the first Enable=1 edge after reset, then sticky until Clear.
- Strobe<=1 iff Enable=1 and ch_next != Channel; otherwise Strobe<=0. Strobe is never high two consecutive cycles for the same change.
- Manual mode (Mode=0): ch_next=Select if Select<CHANNELS; else ch_next=Channel (out-of-range selects are ignored, Channel holds). The dwell counter is held at 0.
- Auto mode (Mode=1, Hold=0):
  - If counter==DWELL-1: counter<=0 and ch_next=Channel+1, wrapping CHANNELS-1 -> 0.
  - Otherwise counter<=counter+1 and ch_next=Channel.
  - Each channel is therefore held for exactly DWELL enabled clocks. DWELL=1 advances every clock.
- Auto mode with Hold=1: counter and Channel are frozen, but out still resamples the current channel each clock.
- Mode switch 1->0: takes effect on the same edge. The counter clears.
- Mode switch 0->1: scanning starts from the current Channel with counter=0.
- Enable=0: out, Channel, counter and Valid hold, and Strobe<=0. Enable has priority over Mode, Hold and Select.
- Clear asserted mid-dwell or mid-scan: immediate return to reset values. After release, auto scan restarts at channel 0 with a full dwell.
- Counter width is ceil(log2(DWELL)), minimum 1. No overflow is possible because it wraps at DWELL-1.

Test Plan:
- Reset, then Enable=1, Mode=0, Select=2, in_bus={8'h44,8'h33,8'h22,8'h11} (ch3..ch0) -> after 1st edge: out=8'h33, Channel=2, Strobe=1, Valid=1; next edge: Strobe=0.
- Mode=0, Select=2 then Select=3 with CHANNELS=3 -> Channel stays 2, out unchanged, Strobe=0.
- Mode=1, DWELL=4, CHANNELS=4 from reset -> Channel sequence 0,0,0,0,1,1,1,1,2,...,3,3,3,3,0. Strobe pulses on the edges where 0->1, 1->2, 2->3 and 3->0 (wrap). out tracks the channel data.
- Auto mode, assert Hold for 5 clocks mid-dwell (counter=2) while changing in_bus ch1 from 8'h22 to 8'h5A -> Channel stays 1, out becomes 8'h5A one clock later. After Hold=0, exactly 2 more clocks before advancing to channel 2.
- Enable=0 for 3 clocks during auto mode -> out, Channel and Valid hold, Strobe=0 throughout, and the scan resumes with the same counter value.
- Assert Clear asynchronously (between edges) at Channel=3 -> out=0, Channel=0, Valid=0 and Strobe=0 immediately, without waiting for a clock edge. After release, the first channel change occurs after DWELL clocks.
